// File: rtl/tx_chan_scheduler_pkg.sv
// Shared types and constants for the TX channel scheduler.
// The state encoding and default gap limit live here so the RX side can reuse them.
package tx_chan_scheduler_pkg;

    localparam int          SAMPLE_W        = 16;
    localparam logic [15:0] GAP_MAX_DEFAULT = 16'd512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

    // Saturating increment, so the gap counter parks at its limit instead of wrapping.
    function automatic logic [15:0] satInc(input logic [15:0] value, input logic [15:0] limit);
        return (value >= limit) ? limit : value + 16'd1;
    endfunction

endpackage

// File: rtl/tx_chan_scheduler_if.sv
// Bundle between the per-channel FIFO readers, the TX chain and the scheduler.
// The master side drives the requests, strobe and samples. The scheduler is the slave side.
interface tx_chan_scheduler_if
    import tx_chan_scheduler_pkg::*;
#(
    parameter int NUM_CHAN = 2,
    parameter int CHW      = 1
);
    logic                         tx_strobe;
    logic [NUM_CHAN-1:0]          pkt_waiting;
    logic [NUM_CHAN-1:0]          skip;
    logic [NUM_CHAN-1:0]          burst;
    logic [NUM_CHAN-1:0]          ch_tx_empty;
    logic [NUM_CHAN*SAMPLE_W-1:0] ch_tx_i;
    logic [NUM_CHAN*SAMPLE_W-1:0] ch_tx_q;
    logic [NUM_CHAN-1:0]          ch_strobe;
    logic [SAMPLE_W-1:0]          tx_i;
    logic [SAMPLE_W-1:0]          tx_q;
    logic                         tx_empty;
    logic                         grant_valid;
    logic [CHW-1:0]               grant_id;
    logic                         burst_abort;

    modport master (
        output tx_strobe, pkt_waiting, skip, burst, ch_tx_empty, ch_tx_i, ch_tx_q,
        input  ch_strobe, tx_i, tx_q, tx_empty, grant_valid, grant_id, burst_abort
    );

    modport slave (
        input  tx_strobe, pkt_waiting, skip, burst, ch_tx_empty, ch_tx_i, ch_tx_q,
        output ch_strobe, tx_i, tx_q, tx_empty, grant_valid, grant_id, burst_abort
    );
endinterface

// File: rtl/tx_chan_scheduler_rr_pick.sv
// Combinational rotating-priority encoder: the search starts one past i_lastId and wraps.
// It has no side-specific logic, so the RX scheduler can use it unchanged.
module rr_pick #(
    parameter int NUM_CHAN = 2,
    parameter int CHW      = 1
) (
    input  logic [NUM_CHAN-1:0] i_req,
    input  logic [CHW-1:0]      i_lastId,
    output logic                o_any,
    output logic [CHW-1:0]      o_winId
);
    localparam int SW = CHW + 1;

    // One extra bit holds lastId+offset before the modulo wrap. A single subtraction is enough because the sum stays below 2*NUM_CHAN.
    always_comb begin
        logic [SW-1:0]  w_sum;
        logic [CHW-1:0] w_cand;
        o_any   = 1'b0;
        o_winId = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int offset = 1; offset <= NUM_CHAN; offset++) begin
            w_sum = {1'b0, i_lastId} + SW'(offset);
            if (w_sum >= SW'(NUM_CHAN)) begin
                w_sum = w_sum - SW'(NUM_CHAN);
            end
            w_cand = w_sum[CHW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any   = 1'b1;
                o_winId = w_cand;
            end
        end
    end

endmodule

// File: rtl/tx_chan_scheduler.sv
// Shares one TX chain among NUM_CHAN FIFO readers. Grants rotate at packet granularity and are held across bursts.
// Only the owning reader receives strobes. Its samples reach the chain one register later.
module tx_chan_scheduler
    import tx_chan_scheduler_pkg::*;
#(
    parameter int          NUM_CHAN = 2,
    parameter int          CHW      = 1,
    parameter logic [15:0] GAP_MAX  = GAP_MAX_DEFAULT
) (
    input  logic               tx_clock,
    input  logic               reset,
    tx_chan_scheduler_if.slave sched
);
    sched_state_t        r_state;
    sched_state_t        w_stateNext;
    logic [CHW-1:0]      r_grantId;
    logic [CHW-1:0]      w_grantIdNext;
    logic [CHW-1:0]      r_lastId;
    logic [CHW-1:0]      w_lastIdNext;
    logic                r_grantValid;
    logic                w_grantValidNext;
    logic [15:0]         r_gapCnt;
    logic [15:0]         w_gapCntNext;
    logic [15:0]         w_gapStep;
    logic                r_burstAbort;
    logic                w_burstAbortNext;
    logic [SAMPLE_W-1:0] r_txI;
    logic [SAMPLE_W-1:0] r_txQ;
    logic                r_txEmpty;

    logic                w_any;
    logic [CHW-1:0]      w_winId;
    logic [CHW-1:0]      w_arbBase;
    logic                w_ownSkip;
    logic                w_ownBurst;
    logic                w_ownWaiting;
    logic [SAMPLE_W-1:0] w_laneI;
    logic [SAMPLE_W-1:0] w_laneQ;
    logic                w_laneEmpty;
    logic [NUM_CHAN-1:0] w_chStrobe;

    // In RELEASE, last_id has not been written yet, so rotation is based on the outgoing owner directly.
    assign w_arbBase = (r_state == ST_RELEASE) ? r_grantId : r_lastId;

    rr_pick #(
        .NUM_CHAN (NUM_CHAN),
        .CHW      (CHW)
    ) u_rrPick (
        .i_req    (sched.pkt_waiting),
        .i_lastId (w_arbBase),
        .o_any    (w_any),
        .o_winId  (w_winId)
    );

    assign w_ownSkip    = sched.skip[r_grantId];
    assign w_ownBurst   = sched.burst[r_grantId];
    assign w_ownWaiting = sched.pkt_waiting[r_grantId];

    // The owner's lane is selected with constant part-selects, so an out-of-range id simply selects nothing.
    always_comb begin
        w_laneI     = '0;
        w_laneQ     = '0;
        w_laneEmpty = 1'b1;
        w_chStrobe  = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (r_grantId == CHW'(k)) begin
                w_laneI     = sched.ch_tx_i[k*SAMPLE_W +: SAMPLE_W];
                w_laneQ     = sched.ch_tx_q[k*SAMPLE_W +: SAMPLE_W];
                w_laneEmpty = sched.ch_tx_empty[k];
            end
            w_chStrobe[k] = sched.tx_strobe & r_grantValid & (r_grantId == CHW'(k));
        end
    end

    assign w_gapStep = sched.tx_strobe ? satInc(r_gapCnt, GAP_MAX) : r_gapCnt;

    // RELEASE re-arbitrates itself, so its cycle is the only dead cycle between owners.
    always_comb begin
        w_stateNext      = r_state;
        w_grantIdNext    = r_grantId;
        w_lastIdNext     = r_lastId;
        w_grantValidNext = r_grantValid;
        w_gapCntNext     = r_gapCnt;
        w_burstAbortNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grantIdNext    = w_winId;
                    w_grantValidNext = 1'b1;
                    w_stateNext      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_ownSkip) begin
                    if (w_ownBurst) begin
                        w_gapCntNext = '0;
                        w_stateNext  = ST_HOLD;
                    end else begin
                        w_grantValidNext = 1'b0;
                        w_stateNext      = ST_RELEASE;
                    end
                end
            end
            ST_HOLD: begin
                if (w_ownWaiting) begin
                    w_stateNext = ST_GRANT;
                end else if (!w_ownBurst) begin
                    w_grantValidNext = 1'b0;
                    w_stateNext      = ST_RELEASE;
                end else begin
                    w_gapCntNext = w_gapStep;
                    if (w_gapStep >= GAP_MAX) begin
                        w_grantValidNext = 1'b0;
                        w_burstAbortNext = 1'b1;
                        w_stateNext      = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                w_lastIdNext = r_grantId;
                if (w_any) begin
                    w_grantIdNext    = w_winId;
                    w_grantValidNext = 1'b1;
                    w_stateNext      = ST_GRANT;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_grantValidNext = 1'b0;
                w_stateNext      = ST_RELEASE;
            end
        endcase
    end

    // Output samples use the current grant, so a cleared grant forces zero/empty one cycle later.
    always_ff @(posedge tx_clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grantId    <= '0;
            r_lastId     <= CHW'(NUM_CHAN - 1);
            r_grantValid <= 1'b0;
            r_gapCnt     <= '0;
            r_burstAbort <= 1'b0;
            r_txI        <= '0;
            r_txQ        <= '0;
            r_txEmpty    <= 1'b1;
        end else begin
            r_state      <= w_stateNext;
            r_grantId    <= w_grantIdNext;
            r_lastId     <= w_lastIdNext;
            r_grantValid <= w_grantValidNext;
            r_gapCnt     <= w_gapCntNext;
            r_burstAbort <= w_burstAbortNext;
            r_txI        <= r_grantValid ? w_laneI : '0;
            r_txQ        <= r_grantValid ? w_laneQ : '0;
            r_txEmpty    <= r_grantValid ? w_laneEmpty : 1'b1;
        end
    end

    assign sched.ch_strobe   = w_chStrobe;
    assign sched.tx_i        = r_txI;
    assign sched.tx_q        = r_txQ;
    assign sched.tx_empty    = r_txEmpty;
    assign sched.grant_valid = r_grantValid;
    assign sched.grant_id    = r_grantId;
    assign sched.burst_abort = r_burstAbort;

endmodule
